// File: rtl/ov7670_packer_types.sv
// Shared types and queue marker words for the OV7670 capture path.
// The frame uploader decodes the same marker constants.
package ov7670_packer_types;

  typedef enum logic [2:0] {
    StIdle,
    StWaitVsync,
    StVsyncActive,
    StWaitRow,
    StRowActive,
    StRowPad,
    StFrameEnd
  } state_e;

  localparam logic [16:0] MARK_FRAME_START = 17'h10000;
  localparam logic [16:0] MARK_ROW_START   = 17'h10001;
  localparam logic [16:0] MARK_FRAME_END   = 17'h1FFFF;
  localparam logic [16:0] PAD_WORD         = 17'h00000;

  function automatic logic [16:0] pack_pixel(input logic [7:0] hi, input logic [7:0] lo);
    return {1'b0, hi, lo};
  endfunction

endpackage

// File: rtl/cam_edge_detect.sv
// Registers camera vsync/href once and produces single-cycle rise/fall strobes
// aligned with the cycle in which the new level is first sampled.
module cam_edge_detect (
  input  logic clk,
  input  logic reset_n,
  input  logic vsync,
  input  logic href,
  output logic vsync_rise,
  output logic vsync_fall,
  output logic href_rise,
  output logic href_fall
);

  logic vsync_q;
  logic href_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
    end else begin
      vsync_q <= vsync;
      href_q  <= href;
    end
  end

  assign vsync_rise = vsync & ~vsync_q;
  assign vsync_fall = ~vsync & vsync_q;
  assign href_rise  = href & ~href_q;
  assign href_fall  = ~href & href_q;

endmodule

// File: rtl/ov7670_frame_packer.sv
// Converts the OV7670 vsync/href/byte stream into 17-bit queue words: RGB565 pixels
// plus frame/row markers, with every forwarded row forced to exactly FRAME_WIDTH pixels.
module ov7670_frame_packer
  import ov7670_packer_types::*;
#(
  parameter int unsigned FRAME_WIDTH  = 640,
  parameter int unsigned FRAME_HEIGHT = 480
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  cam_data,
  input  logic        queue_full,
  output logic        queue_wr_en,
  output logic [16:0] queue_data,
  output logic        frame_done,
  output logic        overflow,
  output logic        frame_error,
  output logic        busy
);

  localparam logic [10:0] Width  = 11'(FRAME_WIDTH);
  localparam logic [10:0] Height = 11'(FRAME_HEIGHT);

  state_e      state;
  logic [10:0] col_cnt;
  logic [10:0] row_cnt;
  logic        phase;
  logic [7:0]  hi_byte;
  logic        pend_valid;
  logic [16:0] pend_word;

  logic vsync_rise, vsync_fall, href_rise, href_fall;

  cam_edge_detect u_edge (
    .clk        (clk),
    .reset_n    (reset_n),
    .vsync      (cam_vsync),
    .href       (cam_href),
    .vsync_rise (vsync_rise),
    .vsync_fall (vsync_fall),
    .href_rise  (href_rise),
    .href_fall  (href_fall)
  );

  logic        drain;
  logic        slot_free;
  logic        mark_req;
  logic [16:0] mark_word;
  logic        pix_done;
  logic        fs_written;

  // The pending marker always owns the queue port first; other words need a free slot.
  assign drain     = pend_valid && !queue_full;
  assign slot_free = !pend_valid && !queue_full;

  always_comb begin
    mark_req  = 1'b0;
    mark_word = MARK_FRAME_START;
    case (state)
      StVsyncActive: mark_req = vsync_fall;
      StWaitRow: begin
        if (!vsync_rise && href_rise && (row_cnt < Height)) begin
          mark_req  = 1'b1;
          mark_word = MARK_ROW_START;
        end
      end
      default: ;
    endcase
  end

  assign pix_done   = (state == StRowActive) && cam_href && phase && (col_cnt < Width);
  assign fs_written = (drain && (pend_word == MARK_FRAME_START)) ||
                      (mark_req && slot_free && (mark_word == MARK_FRAME_START));
  assign busy       = (state != StIdle);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= StIdle;
      col_cnt     <= '0;
      row_cnt     <= '0;
      phase       <= 1'b0;
      hi_byte     <= '0;
      pend_valid  <= 1'b0;
      pend_word   <= '0;
      queue_wr_en <= 1'b0;
      queue_data  <= '0;
      frame_done  <= 1'b0;
      overflow    <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      queue_wr_en <= 1'b0;
      queue_data  <= '0;
      frame_done  <= queue_wr_en && (queue_data == MARK_FRAME_END);

      if (drain) begin
        queue_wr_en <= 1'b1;
        queue_data  <= pend_word;
        pend_valid  <= 1'b0;
      end

      if (mark_req) begin
        if (slot_free) begin
          queue_wr_en <= 1'b1;
          queue_data  <= mark_word;
        end else if (!pend_valid || drain) begin
          pend_valid <= 1'b1;
          pend_word  <= mark_word;
        end else begin
          // Second marker while one is still stuck behind a full queue: flag the loss.
          overflow <= 1'b1;
        end
      end

      if (pix_done) begin
        col_cnt <= col_cnt + 11'd1;
        if (slot_free) begin
          queue_wr_en <= 1'b1;
          queue_data  <= pack_pixel(hi_byte, cam_data);
        end else begin
          overflow <= 1'b1;
        end
      end

      unique case (state)
        StIdle: begin
          if (enable) state <= StWaitVsync;
        end
        StWaitVsync: begin
          if (vsync_rise) state <= StVsyncActive;
        end
        StVsyncActive: begin
          if (vsync_fall) begin
            row_cnt     <= '0;
            frame_error <= 1'b0;
            state       <= StWaitRow;
          end
        end
        StWaitRow: begin
          if (vsync_rise) begin
            state <= StFrameEnd;
          end else if (href_rise && (row_cnt < Height)) begin
            // The href rise cycle already carries the first (high) byte of the row.
            col_cnt <= '0;
            hi_byte <= cam_data;
            phase   <= 1'b1;
            state   <= StRowActive;
          end
        end
        StRowActive: begin
          if (!cam_href) begin
            row_cnt <= row_cnt + 11'd1;
            phase   <= 1'b0;
            state   <= (col_cnt < Width) ? StRowPad : StWaitRow;
          end else if (!phase) begin
            hi_byte <= cam_data;
            phase   <= 1'b1;
          end else begin
            phase <= 1'b0;
          end
        end
        StRowPad: begin
          if (href_rise) frame_error <= 1'b1;
          if (col_cnt >= Width) begin
            state <= StWaitRow;
          end else if (slot_free) begin
            queue_wr_en <= 1'b1;
            queue_data  <= PAD_WORD;
            col_cnt     <= col_cnt + 11'd1;
            if (col_cnt + 11'd1 == Width) state <= StWaitRow;
          end
        end
        StFrameEnd: begin
          if (slot_free) begin
            queue_wr_en <= 1'b1;
            queue_data  <= MARK_FRAME_END;
            if (row_cnt < Height) frame_error <= 1'b1;
            state <= enable ? StVsyncActive : StIdle;
          end
        end
        default: state <= StIdle;
      endcase

      if (fs_written) overflow <= 1'b0;

      // Silence unused-edge warnings for the strobe only relevant implicitly via cam_href.
      if (href_fall && state == StIdle) phase <= 1'b0;
    end
  end

endmodule
